// File: rtl/md_ctrl_pkg.sv
// Shared constants for the multiply/divide controller.
// MD_CTRL_MADD_EN enables the madd/msub accumulate ops.
package md_ctrl_pkg;

    localparam logic [3:0] MDCM    = 4'd0;
    localparam logic [3:0] MDCMU   = 4'd1;
    localparam logic [3:0] MDCD    = 4'd2;
    localparam logic [3:0] MDCDU   = 4'd3;
    localparam logic [3:0] MDCMA   = 4'd4;
    localparam logic [3:0] MDCMS   = 4'd5;

    localparam logic [3:0] MDTHI   = 4'd0;
    localparam logic [3:0] MDTLO   = 4'd1;

    localparam logic [3:0] MD_NONE = 4'b1111;

    localparam int MD_MUL_LAT = 5;
    localparam int MD_DIV_LAT = 10;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } md_state_e;

    function automatic logic md_cop_valid(input logic [3:0] cop);
        logic ok;
        ok = (cop == MDCM) || (cop == MDCMU) ||
             (cop == MDCD) || (cop == MDCDU);
`ifdef MD_CTRL_MADD_EN
        ok = ok || (cop == MDCMA) || (cop == MDCMS);
`endif
        return ok;
    endfunction

    function automatic logic md_cop_div(input logic [3:0] cop);
        return (cop == MDCD) || (cop == MDCDU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit {HI, LO} result for a multiply/divide op.
// MD_CTRL_MADD_EN adds the madd/msub accumulate paths.
module md_arith
    import md_ctrl_pkg::*;
(
    input  logic [3:0]  cop,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [63:0] hilo,
    output logic [63:0] res
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] dvsr;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic               dz;

    // Divisor forced to 1 on zero so the divider never sees x/0.
    assign dz   = (rt == 32'd0);
    assign dvsr = dz ? 32'd1 : rt;

    always_comb begin
        prod_s = $signed(rs) * $signed(rt);
        prod_u = {32'd0, rs} * {32'd0, rt};
        quo_s  = $signed(rs) / $signed(dvsr);
        rem_s  = $signed(rs) % $signed(dvsr);
        quo_u  = rs / dvsr;
        rem_u  = rs % dvsr;
    end

    always_comb begin
        res = hilo;
        case (cop)
            MDCM:  res = prod_s;
            MDCMU: res = prod_u;
            MDCD:  res = dz ? hilo : {rem_s, quo_s};
            MDCDU: res = dz ? hilo : {rem_u, quo_u};
`ifdef MD_CTRL_MADD_EN
            MDCMA: res = hilo + prod_s;
            MDCMS: res = hilo - prod_s;
`endif
            default: res = hilo;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, busy counter and D stall.
// MD_CTRL_MADD_EN enables madd/msub (cop 4/5) with MUL_LAT latency.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT,
    parameter int DIV_LAT = MD_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [3:0]  md_cop,
    input  logic [3:0]  md_wop,
    input  logic        md_rop,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        exc_req,
    input  logic        d_md_flag,
    output logic        md_busy,
    output logic [31:0] md_rdata,
    output logic        md_stall
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    md_state_e     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   hi, lo;
    logic [63:0]   hold;
    logic [63:0]   res;
    logic          start_ok;
    logic          wr_ok;
    logic          hold_ld;
    logic          hilo_ld;

    md_arith u_arith (
        .cop  (md_cop),
        .rs   (rs_data),
        .rt   (rt_data),
        .hilo ({hi, lo}),
        .res  (res)
    );

    assign md_busy  = (cnt != '0);
    assign start_ok = md_start && !exc_req && !md_busy &&
                      md_cop_valid(md_cop);
    assign wr_ok    = !md_busy && !exc_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hold_ld = 1'b0;
        hilo_ld = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    hold_ld = 1'b1;
                    state_n = ST_BUSY;
                    cnt_n   = md_cop_div(md_cop) ?
                              CW'(DIV_LAT) : CW'(MUL_LAT);
                end
            end
            ST_BUSY: begin
                cnt_n = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    hilo_ld = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
        end else if (hold_ld) begin
            hold <= res;
        end
    end

    // HI/LO cannot change while busy, so the result held at acceptance
    // already reflects the committed {HI, LO} seen at completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (hilo_ld) begin
            hi <= hold[63:32];
            lo <= hold[31:0];
        end else if (wr_ok) begin
            if (md_wop == MDTHI) hi <= rs_data;
            if (md_wop == MDTLO) lo <= rs_data;
        end
    end

    assign md_rdata = md_rop ? lo : hi;
    assign md_stall = d_md_flag && (md_busy || md_start);

endmodule
